// File: rtl/vga_fb_write_arbiter.sv
// Round-robin arbiter sharing the frame buffer pixel write port between NUM_REQ producers.
// Bursts are capped at MAX_BURST beats; optional tear-free mode gates writes to vblank.
module vga_fb_write_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned PIXEL_DEPTH = 8,
    parameter int unsigned FB_DEPTH    = 76800,
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned MAX_BURST   = 16
) (
    input  logic                              pxclk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*PIXEL_DEPTH-1:0]    req_data,
    input  logic                              vblank,
    input  logic                              blank_only,
    output logic                              fb_we,
    output logic [ADDR_WIDTH-1:0]             fb_addr,
    output logic [PIXEL_DEPTH-1:0]            fb_wdata,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              drop
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                 state_q, state_d;
    logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]         grant_id_q, grant_id_d;
    logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                   fb_we_q, drop_q;
    logic [ADDR_WIDTH-1:0]  fb_addr_q;
    logic [PIXEL_DEPTH-1:0] fb_wdata_q;

    logic                   allow;
    logic                   g_valid, g_last;
    logic [ADDR_WIDTH-1:0]  g_addr;
    logic [PIXEL_DEPTH-1:0] g_data;
    logic                   xfer;
    logic                   burst_end;
    logic                   in_range;
    logic [IdW-1:0]         rr_next;
    logic                   arb_found;
    logic [IdW-1:0]         arb_win;

    assign allow     = !blank_only || vblank;
    assign g_valid   = req_valid[grant_id_q];
    assign g_last    = req_last[grant_id_q];
    assign g_addr    = req_addr[grant_id_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign g_data    = req_data[grant_id_q*PIXEL_DEPTH +: PIXEL_DEPTH];
    // Ready is gated by rst_n so a beat presented during reset is never consumed.
    assign xfer      = (state_q == StGrant) && allow && rst_n && g_valid;
    assign burst_end = (beat_cnt_q == CntW'(MAX_BURST - 1));
    assign in_range  = 32'(g_addr) < FB_DEPTH;
    assign rr_next   = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        logic [IdW-1:0] idx;
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[idx]) begin
                arb_found = 1'b1;
                arb_win   = idx;
            end
        end
    end

    // State register
    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (allow && arb_found) begin
                    state_d    = StGrant;
                    grant_id_d = arb_win;
                    beat_cnt_d = '0;
                end
            end
            StGrant: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (g_last || burst_end) begin
                        state_d  = StIdle;
                        rr_ptr_d = rr_next;
                    end
                end else if (allow && !g_valid) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        if ((state_q == StGrant) && allow && rst_n) begin
            req_ready[grant_id_q] = 1'b1;
        end
        busy = (state_q == StGrant);
    end

    // Registered write port; address/data hold unless a real write occurs.
    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            fb_we_q    <= 1'b0;
            drop_q     <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            fb_we_q <= xfer && in_range;
            drop_q  <= xfer && !in_range;
            if (xfer && in_range) begin
                fb_addr_q  <= g_addr;
                fb_wdata_q <= g_data;
            end
        end
    end

    assign fb_we    = fb_we_q;
    assign drop     = drop_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign grant_id = grant_id_q;

endmodule

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Shares the single pixel write port of the VGA frame buffer between NUM_REQ pixel producers (e.g. CPU bridge, fill/blit engine, text renderer).
- Round-robin arbitration with bounded bursts.
- Optional tear-free mode restricts writes to vertical blanking.
- Lives in the pxclk domain beside the VGA timing generator and frame buffer.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- PIXEL_DEPTH, 8, bits per pixel on the write port
- FB_DEPTH, 76800, number of pixel locations in the frame buffer
- ADDR_WIDTH, 17, pixel address width (>= clog2(FB_DEPTH))
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (>= 1)

Ports:
- pxclk  input  1  pixel clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_ready  output  NUM_REQ  per-requester beat accept
- req_last  input  NUM_REQ  marks final beat of a requester's burst
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed pixel addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*PIXEL_DEPTH  packed pixel data, same packing
- vblank  input  1  high during vertical blanking (from timing generator)
- blank_only  input  1  1 = writes only permitted while vblank is high
- fb_we  output  1  frame buffer write enable
- fb_addr  output  ADDR_WIDTH  frame buffer write address
- fb_wdata  output  PIXEL_DEPTH  frame buffer write data
- grant_id  output  clog2(NUM_REQ)  current or last granted requester
- busy  output  1  high while in GRANT state
- drop  output  1  one-cycle pulse: an accepted beat was discarded (address >= FB_DEPTH)

Behaviour:
- Reset (rst_n low at a pxclk edge), regardless of state:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - fb_we=0, fb_addr=0, fb_wdata=0, grant_id=0, drop=0.
  - req_ready=0 immediately (combinational from state); any in-flight burst is abandoned, no write issued.
- allow = !blank_only || vblank (combinational).
- IDLE:
  - If allow and any req_valid: select the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register grant_id=winner, beat_cnt=0, go to GRANT.
  - Otherwise stay in IDLE. Arbitration costs exactly one cycle; req_ready is 0 in IDLE.
- GRANT:
  - req_ready[i] = (i==grant_id) && allow; all other requesters see 0.
  - Transfer = req_valid[g] && req_ready[g]. On a transfer, beat_cnt increments.
  - Exit to IDLE after a transfer with req_last[g]=1, or after the transfer that makes beat_cnt==MAX_BURST; set rr_ptr=(grant_id+1) mod NUM_REQ.
  - Exit to IDLE if allow=1 and req_valid[g]=0 (requester went idle); rr_ptr updated the same way.
  - If allow=0 (vblank fell mid-burst in blank_only mode), hold GRANT with ready low, keep grant_id and beat_cnt, and resume when allow returns. Other requesters are not served meanwhile.
- Write port, registered, latency 1:
  - A transfer at edge N with address < FB_DEPTH gives fb_we=1, fb_addr/fb_wdata = beat values for cycle N+1.
  - A transfer with address >= FB_DEPTH gives fb_we=0 and drop=1 for cycle N+1.
  - Otherwise fb_we=0 and drop=0; fb_addr/fb_wdata hold their last values.
- Other outputs:
  - busy = (state==GRANT).
  - grant_id holds its value in IDLE until the next win.
- Throughput and fairness:
  - Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
  - A continuously requesting requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles of arbitration/grant time while allow=1.
- Changing blank_only takes effect combinationally on the next cycle's ready; no beat is lost or duplicated.

Test Plan:
- Reset then single request: req 1 valid, addr=0x00010, data=0xA5, last=1 → ready[1] high on cycle 2; fb_we=1, fb_addr=0x10, fb_wdata=0xA5 on cycle 3; rr_ptr=2; busy low on cycle 3.
- Round-robin: all 3 requesters continuously valid with last=1 each beat → grant order 0,1,2,0,1,2; one write every 2 cycles.
- Burst cap: MAX_BURST=16, req 0 streams 20 beats without last while req 2 also valid → 16 writes from req 0, one idle cycle, then req 2 granted; req 0's remaining 4 beats follow after req 2.
- Tear-free: blank_only=1, vblank=0 with req 0 valid → no ready, no fb_we; vblank rises → writes begin. vblank falls after beat 3 of 8 → ready drops, grant held; beats 4..8 complete after the next vblank rise, busy stays high throughout.
- Out-of-range: addr=76800 accepted → fb_we=0, drop=1 for one cycle; next beat at addr=76799 → fb_we=1, drop=0.
- Reset mid-burst: rst_n low during beat 5 of req 1 → next cycle ready=0, fb_we=0, busy=0, grant_id=0; after release, req 1 arbitrates fresh from rr_ptr=0.
